// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle restoring radix-2 integer divider, AXI-stream operand/result channels
// Operands are captured independently; the result pulse carries {quotient, remainder}.
module div_iter #(
  parameter int SIGNED = 1,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  state_t              state_next;

  logic                a_full;
  logic                b_full;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic                cap_a;
  logic                cap_b;
  logic                start;
  logic [DATA_W-1:0]   a_val;
  logic [DATA_W-1:0]   b_val;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W:0]     b_mag;

  logic [DATA_W:0]     mag_b;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   dq;
  logic                sign_q;
  logic                sign_r;
  logic [CW-1:0]       cnt;
  logic                last;

  logic [DATA_W+1:0]   trial;
  logic [DATA_W+1:0]   diff;
  logic [DATA_W:0]     rem_next;
  logic [DATA_W-1:0]   dq_next;
  logic [DATA_W-1:0]   q_res;
  logic [DATA_W-1:0]   r_res;

  assign s_axis_dividend_tready = (state == IDLE) && !a_full;
  assign s_axis_divisor_tready  = (state == IDLE) && !b_full;
  assign cap_a = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign cap_b = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign start = (state == IDLE) && (a_full || cap_a) && (b_full || cap_b);

  // Operand seen by the start logic: the held slot, or the value arriving this edge
  assign a_val = a_full ? a_reg : s_axis_dividend_tdata;
  assign b_val = b_full ? b_reg : s_axis_divisor_tdata;
  assign a_neg = (SIGNED != 0) && a_val[DATA_W-1];
  assign b_neg = (SIGNED != 0) && b_val[DATA_W-1];
  assign a_mag = a_neg ? -a_val : a_val;
  assign b_mag = b_neg ? -{1'b1, b_val} : {1'b0, b_val};

  // Sign of the widened difference tells whether the trial subtraction fits
  assign trial    = {rem, dq[DATA_W-1]};
  assign diff     = trial - {1'b0, mag_b};
  assign rem_next = diff[DATA_W+1] ? trial[DATA_W:0] : diff[DATA_W:0];
  assign dq_next  = {dq[DATA_W-2:0], !diff[DATA_W+1]};
  assign last     = (cnt == CW'(DATA_W - 1));

  always_comb begin
    q_res = sign_q ? -dq_next : dq_next;
    r_res = sign_r ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];
    if (b_reg == '0) begin
      q_res = '1;
      r_res = a_reg;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      a_full             <= 1'b0;
      b_full             <= 1'b0;
      a_reg              <= '0;
      b_reg              <= '0;
      mag_b              <= '0;
      rem                <= '0;
      dq                 <= '0;
      sign_q             <= 1'b0;
      sign_r             <= 1'b0;
      cnt                <= '0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      if (cap_a) begin
        a_full <= 1'b1;
        a_reg  <= s_axis_dividend_tdata;
      end
      if (cap_b) begin
        b_full <= 1'b1;
        b_reg  <= s_axis_divisor_tdata;
      end
      if (start) begin
        rem    <= '0;
        dq     <= a_mag;
        mag_b  <= b_mag;
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
        cnt    <= '0;
      end
      if (state == CALC) begin
        rem <= rem_next;
        dq  <= dq_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          m_axis_dout_tdata  <= {q_res, r_res};
          m_axis_dout_tvalid <= 1'b1;
        end
      end
      if (state == DONE) begin
        a_full <= 1'b0;
        b_full <= 1'b0;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed and random checks of div_iter, signed and unsigned instances
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] a_data [2];
  logic [31:0] b_data [2];
  logic        a_vld  [2];
  logic        b_vld  [2];
  logic        a_rdy  [2];
  logic        b_rdy  [2];
  logic [63:0] dout   [2];
  logic        dvld   [2];

  int          checks = 0;
  int          errors = 0;
  int          pushed = 0;
  int          pulses_seen = 0;
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];

  always #5 clk = ~clk;

  div_iter #(.SIGNED(1), .DATA_W(32)) u_s (
    .aclk(clk), .resetn(resetn),
    .s_axis_dividend_tdata(a_data[0]), .s_axis_dividend_tvalid(a_vld[0]), .s_axis_dividend_tready(a_rdy[0]),
    .s_axis_divisor_tdata(b_data[0]), .s_axis_divisor_tvalid(b_vld[0]), .s_axis_divisor_tready(b_rdy[0]),
    .m_axis_dout_tdata(dout[0]), .m_axis_dout_tvalid(dvld[0])
  );

  div_iter #(.SIGNED(0), .DATA_W(32)) u_u (
    .aclk(clk), .resetn(resetn),
    .s_axis_dividend_tdata(a_data[1]), .s_axis_dividend_tvalid(a_vld[1]), .s_axis_dividend_tready(a_rdy[1]),
    .s_axis_divisor_tdata(b_data[1]), .s_axis_divisor_tvalid(b_vld[1]), .s_axis_divisor_tready(b_rdy[1]),
    .m_axis_dout_tdata(dout[1]), .m_axis_dout_tvalid(dvld[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int inst, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (inst == 0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Result monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dvld[i]) begin
        pulses_seen++;
        if (i == 0) begin
          if (exp_q0.size() == 0) check("pulse_s_without_request", 64'(exp_q0.size()), 64'd1);
          else check("dout_signed", dout[0], exp_q0.pop_front());
        end else begin
          if (exp_q1.size() == 0) check("pulse_u_without_request", 64'(exp_q1.size()), 64'd1);
          else check("dout_unsigned", dout[1], exp_q1.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!(a_rdy[i] && b_rdy[i]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 64'(n), 64'd0);
  endtask

  task automatic push(input int i, input logic [63:0] e);
    if (i == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    pushed++;
  endtask

  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    wait_ready(i);
    a_data[i] = a;
    b_data[i] = b;
    a_vld[i]  = 1'b1;
    b_vld[i]  = 1'b1;
    @(posedge clk);
    #1;
    a_vld[i]  = 1'b0;
    b_vld[i]  = 1'b0;
    a_data[i] = $urandom;
    b_data[i] = $urandom;
    push(i, e);
  endtask

  // Counts edges after the capture edge until the result pulse is visible
  task automatic wait_pulse(input int i, output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (dvld[i]) break;
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_data[i] = $urandom;
      b_data[i] = $urandom;
      a_vld[i]  = 1'b1;
      b_vld[i]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_dividend_tready", 64'(a_rdy[i]), 64'd1);
      check("reset_divisor_tready", 64'(b_rdy[i]), 64'd1);
      check("reset_dout_tvalid", 64'(dvld[i]), 64'd0);
      check("reset_dout_tdata", dout[i], 64'd0);
      a_vld[i] = 1'b0;
      b_vld[i] = 1'b0;
    end
    resetn = 1'b1;

    // Unsigned 100/7 with both operands on the same edge
    put(1, 32'd100, 32'd7, {32'd14, 32'd2});
    check("busy_dividend_tready", 64'(a_rdy[1]), 64'd0);
    check("busy_divisor_tready", 64'(b_rdy[1]), 64'd0);
    wait_pulse(1, n);
    check("latency_100_7", 64'(n), 64'd32);
    @(posedge clk);
    #1;
    check("pulse_width", 64'(dvld[1]), 64'd0);
    check("after_dividend_tready", 64'(a_rdy[1]), 64'd1);
    check("after_divisor_tready", 64'(b_rdy[1]), 64'd1);
    check("dout_holds", dout[1], {32'd14, 32'd2});

    // Signed sign rules
    put(0, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    wait_pulse(0, n);
    check("latency_signed", 64'(n), 64'd32);
    put(0, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1});
    wait_pulse(0, n);

    // Dividend first, divisor five cycles later
    wait_ready(0);
    a_data[0] = 32'd101;
    a_vld[0]  = 1'b1;
    @(posedge clk);
    #1;
    a_vld[0] = 1'b0;
    check("split_dividend_tready", 64'(a_rdy[0]), 64'd0);
    check("split_divisor_tready", 64'(b_rdy[0]), 64'd1);
    repeat (5) @(negedge clk);
    check("split_still_waiting", 64'(a_rdy[0]), 64'd0);
    check("split_no_early_pulse", 64'(dvld[0]), 64'd0);
    b_data[0] = 32'hFFFF_FFFB;
    b_vld[0]  = 1'b1;
    @(posedge clk);
    #1;
    b_vld[0] = 1'b0;
    push(0, {32'hFFFF_FFEC, 32'd1});
    wait_pulse(0, n);
    check("latency_from_divisor", 64'(n), 64'd32);

    // Overflow and divide by zero
    put(0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
    wait_pulse(0, n);
    put(0, 32'h0000_1234, 32'd0, {32'hFFFF_FFFF, 32'h0000_1234});
    wait_pulse(0, n);
    put(0, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFF8});
    wait_pulse(0, n);
    put(1, 32'h0000_1234, 32'd0, {32'hFFFF_FFFF, 32'h0000_1234});
    wait_pulse(1, n);
    put(1, 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0});
    wait_pulse(1, n);

    // Reset part-way through CALC aborts the operation
    wait_ready(1);
    a_data[1] = 32'd100;
    b_data[1] = 32'd7;
    a_vld[1]  = 1'b1;
    b_vld[1]  = 1'b1;
    @(posedge clk);
    #1;
    a_vld[1] = 1'b0;
    b_vld[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("abort_dividend_tready", 64'(a_rdy[1]), 64'd1);
    check("abort_divisor_tready", 64'(b_rdy[1]), 64'd1);
    check("abort_dout_tdata", dout[1], 64'd0);
    repeat (40) @(posedge clk);
    put(1, 32'd9, 32'd3, {32'd3, 32'd0});
    wait_pulse(1, n);
    check("latency_after_abort", 64'(n), 64'd32);

    // Random back-to-back traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      ra = pick();
      rb = pick();
      put(0, ra, rb, model(0, ra, rb));
    end
    for (int k = 0; k < 150; k++) begin
      ra = pick();
      rb = pick();
      put(1, ra, rb, model(1, ra, rb));
    end

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check("signed_queue_drained", 64'(exp_q0.size()), 64'd0);
    check("unsigned_queue_drained", 64'(exp_q1.size()), 64'd0);
    check("one_pulse_per_pair", 64'(pulses_seen), 64'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
